// File: rtl/bcd_digit_collector.sv
// Serial BCD digit collector: shifts in one digit per handshake (MSD first) and
// holds each completed word on a valid/ready output. Optional BCD_COLLECT_ERRCNT_EN adds err_count.
module bcd_digit_collector #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              digit_in,
  input  logic                    digit_valid,
  output logic                    digit_ready,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] word_out,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    digit_err
`ifdef BCD_COLLECT_ERRCNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS) + 1;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    word_q, word_d;
  logic            err_q, err_d;
  logic            accept;
  logic            bad_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    err_d       = 1'b0;
    digit_ready = (state_q == COLLECT) && !clear;
    accept      = digit_valid && digit_ready;
    bad_digit   = digit_in > 4'd9;

    // clear outranks both the digit handshake and the word handshake
    if (clear) begin
      state_d = COLLECT;
      cnt_d   = '0;
      word_d  = '0;
    end else if (state_q == HOLD) begin
      if (word_ready) begin
        state_d = COLLECT;
        word_d  = '0;
      end
    end else if (accept) begin
      if (bad_digit) begin
        cnt_d  = '0;
        word_d = '0;
        err_d  = 1'b1;
      end else begin
        word_d = (word_q << 4) | W'(digit_in);
        if (cnt_q == CW'(NUM_DIGITS - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  assign word_out   = word_q;
  assign word_valid = (state_q == HOLD);
  assign digit_err  = err_q;

`ifdef BCD_COLLECT_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating tally of rejected digits; only rst clears it.
  always_comb begin
    err_count_d = err_count_q;
    if (accept && bad_digit && err_count_q != 8'hFF)
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule
